// File: rtl/udma_spim_cmd_seq.sv
// Command sequencer between the uDMA command channel and the SPI master engine.
// Control-flow opcodes are executed here; all other opcodes go to the engine.
module udma_spim_cmd_seq #(
  parameter int RPT_WIDTH  = 16,
  parameter int WAIT_WIDTH = 8
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [31:0] cmd_data_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  output logic [31:0] spi_cmd_o,
  output logic        spi_cmd_valid_o,
  input  logic        spi_cmd_ready_i,
  input  logic        spi_idle_i,
  input  logic        clr_i,
  output logic        eot_event_o,
  output logic        busy_o
);

  localparam logic [3:0] OP_WAIT = 4'h5;
  localparam logic [3:0] OP_RPT  = 4'h8;
  localparam logic [3:0] OP_EOT  = 4'h9;
  localparam logic [3:0] OP_UCA  = 4'hD;
  localparam logic [3:0] OP_UCS  = 4'hE;

  localparam logic [RPT_WIDTH-1:0]  RPT_ZERO  = '0;
  localparam logic [RPT_WIDTH-1:0]  RPT_ONE   = RPT_WIDTH'(1);
  localparam logic [WAIT_WIDTH-1:0] WAIT_ZERO = '0;
  localparam logic [WAIT_WIDTH-1:0] WAIT_ONE  = WAIT_WIDTH'(1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FWD       = 3'd1,
    ST_WAIT_CNT  = 3'd2,
    ST_WAIT_IDLE = 3'd3,
    ST_EOT       = 3'd4
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [31:0]           r_spi_cmd, w_spi_cmd_nxt;
  logic [RPT_WIDTH-1:0]  r_rpt_cnt, w_rpt_cnt_nxt;
  logic                  r_rpt_pend, w_rpt_pend_nxt;
  logic [RPT_WIDTH-1:0]  r_iss_cnt, w_iss_cnt_nxt;
  logic [WAIT_WIDTH-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic                  r_wait_idle, w_wait_idle_nxt;

  logic       w_cmd_ready;
  logic       w_accept;
  logic       w_eot_fire;
  logic [3:0] w_op;

  assign w_op        = cmd_data_i[31:28];
  assign w_cmd_ready = (r_state == ST_IDLE) & ~clr_i;
  assign w_accept    = cmd_valid_i & w_cmd_ready;
  // An abort suppresses the end-of-transfer pulse even if it would fire this cycle.
  assign w_eot_fire  = (r_state == ST_EOT) & ~clr_i & (~r_wait_idle | spi_idle_i);

  assign cmd_ready_o     = w_cmd_ready;
  assign spi_cmd_o       = r_spi_cmd;
  assign spi_cmd_valid_o = (r_state == ST_FWD);
  assign eot_event_o     = w_eot_fire;
  assign busy_o          = (r_state != ST_IDLE);

  // Next-state and next-register computation.
  always_comb begin
    w_state_nxt     = r_state;
    w_spi_cmd_nxt   = r_spi_cmd;
    w_rpt_cnt_nxt   = r_rpt_cnt;
    w_rpt_pend_nxt  = r_rpt_pend;
    w_iss_cnt_nxt   = r_iss_cnt;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_wait_idle_nxt = r_wait_idle;
    if (clr_i) begin
      w_state_nxt     = ST_IDLE;
      w_rpt_cnt_nxt   = RPT_ZERO;
      w_rpt_pend_nxt  = 1'b0;
      w_iss_cnt_nxt   = RPT_ZERO;
      w_wait_cnt_nxt  = WAIT_ZERO;
      w_wait_idle_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            case (w_op)
              OP_WAIT: begin
                if (cmd_data_i[27]) begin
                  w_state_nxt = ST_WAIT_IDLE;
                end else begin
                  w_wait_cnt_nxt = cmd_data_i[WAIT_WIDTH-1:0];
                  if (cmd_data_i[WAIT_WIDTH-1:0] != WAIT_ZERO) begin
                    w_state_nxt = ST_WAIT_CNT;
                  end else begin
                    w_state_nxt = ST_IDLE;
                  end
                end
              end
              OP_RPT: begin
                w_rpt_cnt_nxt  = cmd_data_i[RPT_WIDTH-1:0];
                w_rpt_pend_nxt = 1'b1;
              end
              OP_EOT: begin
                w_wait_idle_nxt = cmd_data_i[0];
                w_rpt_pend_nxt  = 1'b0;
                w_state_nxt     = ST_EOT;
              end
              OP_UCA, OP_UCS: begin
                w_state_nxt = ST_IDLE;
              end
              default: begin
                w_spi_cmd_nxt = cmd_data_i;
                // A repeat count of zero still issues the command once.
                if (r_rpt_pend && (r_rpt_cnt != RPT_ZERO)) begin
                  w_iss_cnt_nxt = r_rpt_cnt;
                end else begin
                  w_iss_cnt_nxt = RPT_ONE;
                end
                w_rpt_pend_nxt = 1'b0;
                w_state_nxt    = ST_FWD;
              end
            endcase
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_FWD: begin
          if (spi_cmd_ready_i) begin
            if (r_iss_cnt > RPT_ONE) begin
              w_iss_cnt_nxt = r_iss_cnt - RPT_ONE;
            end else begin
              w_iss_cnt_nxt = RPT_ZERO;
              w_state_nxt   = ST_IDLE;
            end
          end else begin
            w_state_nxt = ST_FWD;
          end
        end
        ST_WAIT_CNT: begin
          if (r_wait_cnt > WAIT_ONE) begin
            w_wait_cnt_nxt = r_wait_cnt - WAIT_ONE;
          end else begin
            w_wait_cnt_nxt = WAIT_ZERO;
            w_state_nxt    = ST_IDLE;
          end
        end
        ST_WAIT_IDLE: begin
          if (spi_idle_i) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_WAIT_IDLE;
          end
        end
        ST_EOT: begin
          if (w_eot_fire) begin
            w_state_nxt     = ST_IDLE;
            w_wait_idle_nxt = 1'b0;
          end else begin
            w_state_nxt = ST_EOT;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= ST_IDLE;
      r_spi_cmd   <= 32'h0000_0000;
      r_rpt_cnt   <= RPT_ZERO;
      r_rpt_pend  <= 1'b0;
      r_iss_cnt   <= RPT_ZERO;
      r_wait_cnt  <= WAIT_ZERO;
      r_wait_idle <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_spi_cmd   <= w_spi_cmd_nxt;
      r_rpt_cnt   <= w_rpt_cnt_nxt;
      r_rpt_pend  <= w_rpt_pend_nxt;
      r_iss_cnt   <= w_iss_cnt_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
      r_wait_idle <= w_wait_idle_nxt;
    end
  end

endmodule

// File: tb/tb_udma_spim_cmd_seq.sv
// Directed plus randomized bench for udma_spim_cmd_seq; expectations come from
// a command-level model of repeat state, issue counts and per-opcode timing.
module tb_udma_spim_cmd_seq;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [31:0] cmd_data_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [31:0] spi_cmd_o;
  logic        spi_cmd_valid_o;
  logic        spi_cmd_ready_i;
  logic        spi_idle_i;
  logic        clr_i;
  logic        eot_event_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  // Model of the repeat prefix state.
  logic        m_rpt_pend;
  logic [15:0] m_rpt_cnt;

  udma_spim_cmd_seq dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .cmd_data_i(cmd_data_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .spi_cmd_o(spi_cmd_o), .spi_cmd_valid_o(spi_cmd_valid_o),
    .spi_cmd_ready_i(spi_cmd_ready_i), .spi_idle_i(spi_idle_i),
    .clr_i(clr_i), .eot_event_o(eot_event_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fwd_word();
    logic [3:0] op;
    op = 4'($urandom_range(0, 15));
    while (op == 4'h5 || op == 4'h8 || op == 4'h9 || op == 4'hD || op == 4'hE)
      op = 4'($urandom_range(0, 15));
    return {op, 28'($urandom)};
  endfunction

  // Presents one word; returns in the cycle after the accepting edge.
  task automatic send(input logic [31:0] w);
    cmd_data_i  = w;
    cmd_valid_i = 1'b1;
    #1;
    check("ready_at_send", 32'(cmd_ready_o), 32'd1);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    cmd_data_i  = $urandom;
  endtask

  task automatic do_fwd(input logic [31:0] w, input int stall, input bit rnd);
    int n, hs, cyc;
    bit rdy;
    n = (m_rpt_pend && m_rpt_cnt != 16'd0) ? int'(m_rpt_cnt) : 1;
    m_rpt_pend = 1'b0;
    send(w);
    hs = 0;
    cyc = 0;
    while (hs < n && cyc < 400) begin
      if (cyc < stall) rdy = 1'b0;
      else if (!rnd || cyc > stall + 8) rdy = 1'b1;
      else rdy = 1'($urandom_range(0, 1));
      spi_cmd_ready_i = rdy;
      #1;
      check("fwd_valid", 32'(spi_cmd_valid_o), 32'd1);
      check("fwd_word", spi_cmd_o, w);
      check("fwd_ready_low", 32'(cmd_ready_o), 32'd0);
      check("fwd_no_eot", 32'(eot_event_o), 32'd0);
      @(negedge clk_i);
      cyc++;
      if (rdy) hs++;
    end
    spi_cmd_ready_i = 1'b0;
    #1;
    check("fwd_issues", 32'(hs), 32'(n));
    if (!rnd) check("fwd_cycles", 32'(cyc), 32'(stall + n));
    check("fwd_valid_done", 32'(spi_cmd_valid_o), 32'd0);
    check("fwd_ready_back", 32'(cmd_ready_o), 32'd1);
    check("fwd_busy_done", 32'(busy_o), 32'd0);
  endtask

  task automatic do_wait(input logic [7:0] n);
    send({4'h5, 1'b0, 19'h0, n});
    for (int k = 0; k < int'(n); k++) begin
      #1;
      check("wait_ready_low", 32'(cmd_ready_o), 32'd0);
      check("wait_busy", 32'(busy_o), 32'd1);
      @(negedge clk_i);
    end
    #1;
    check("wait_ready_back", 32'(cmd_ready_o), 32'd1);
  endtask

  task automatic do_wait_idle();
    int cyc;
    bit idl;
    send({4'h5, 1'b1, 27'($urandom)});
    cyc = 0;
    idl = 1'b0;
    while (!idl && cyc < 50) begin
      idl = (cyc >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
      spi_idle_i = idl;
      #1;
      check("widle_ready_low", 32'(cmd_ready_o), 32'd0);
      @(negedge clk_i);
      cyc++;
    end
    #1;
    check("widle_ready_back", 32'(cmd_ready_o), 32'd1);
  endtask

  task automatic do_eot(input bit w0, input int low);
    int cyc, pulses;
    bit exp;
    m_rpt_pend = 1'b0;
    send({4'h9, 27'($urandom), w0});
    cyc = 0;
    pulses = 0;
    exp = 1'b0;
    while (!exp && cyc < 50) begin
      if (cyc < low) spi_idle_i = 1'b0;
      else if (cyc >= low + 6) spi_idle_i = 1'b1;
      else spi_idle_i = 1'($urandom_range(0, 1));
      exp = !w0 || spi_idle_i;
      #1;
      check("eot_pulse", 32'(eot_event_o), 32'(exp));
      check("eot_busy", 32'(busy_o), 32'd1);
      @(negedge clk_i);
      cyc++;
    end
    #1;
    check("eot_after", 32'(eot_event_o), 32'd0);
    check("eot_ready_back", 32'(cmd_ready_o), 32'd1);
  endtask

  task automatic do_rpt(input logic [15:0] c);
    send({4'h8, 12'($urandom), c});
    m_rpt_cnt  = c;
    m_rpt_pend = 1'b1;
    #1;
    check("rpt_ready", 32'(cmd_ready_o), 32'd1);
    check("rpt_busy", 32'(busy_o), 32'd0);
  endtask

  task automatic do_setup(input logic [3:0] op);
    send({op, 28'($urandom)});
    #1;
    check("setup_ready", 32'(cmd_ready_o), 32'd1);
    check("setup_busy", 32'(busy_o), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"}, 32'(spi_cmd_valid_o), 32'd0);
    check({tag, "_cmd"}, spi_cmd_o, 32'd0);
    check({tag, "_eot"}, 32'(eot_event_o), 32'd0);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_ready"}, 32'(cmd_ready_o), 32'd1);
  endtask

  task automatic pulse_reset(input string tag);
    rstn_i = 1'b0;
    #1;
    check_reset_vals(tag);
    @(negedge clk_i);
    rstn_i     = 1'b1;
    m_rpt_pend = 1'b0;
    m_rpt_cnt  = 16'd0;
  endtask

  initial begin
    int kind;
    logic [31:0] w;
    rstn_i = 1'b0;
    cmd_data_i = 32'd0;
    cmd_valid_i = 1'b0;
    spi_cmd_ready_i = 1'b0;
    spi_idle_i = 1'b0;
    clr_i = 1'b0;
    m_rpt_pend = 1'b0;
    m_rpt_cnt = 16'd0;
    #1;
    check_reset_vals("reset");
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;

    // Stalled forward, then repeat around a SETUP_UCA.
    do_fwd({4'h2, 28'h0ABCDEF}, 3, 1'b0);
    do_rpt(16'd3);
    do_setup(4'hD);
    do_fwd(fwd_word(), 0, 1'b0);
    do_wait(8'd5);
    do_wait(8'd0);
    do_fwd(fwd_word(), 0, 1'b0);

    // EOT waiting on idle clears a pending repeat.
    do_rpt(16'd3);
    do_eot(1'b1, 4);
    do_fwd(fwd_word(), 0, 1'b0);
    do_eot(1'b0, 0);
    do_rpt(16'd0);
    do_fwd(fwd_word(), 0, 1'b0);

    // Abort during a stalled repeat with two issues outstanding.
    do_rpt(16'd3);
    m_rpt_pend = 1'b0;
    w = fwd_word();
    send(w);
    spi_cmd_ready_i = 1'b1;
    #1;
    check("clr_first_issue", 32'(spi_cmd_valid_o), 32'd1);
    @(negedge clk_i);
    spi_cmd_ready_i = 1'b0;
    #1;
    check("clr_stall_valid", 32'(spi_cmd_valid_o), 32'd1);
    @(negedge clk_i);
    clr_i = 1'b1;
    #1;
    check("clr_ready_gated", 32'(cmd_ready_o), 32'd0);
    check("clr_stall_word", spi_cmd_o, w);
    @(negedge clk_i);
    clr_i = 1'b0;
    #1;
    check("clr_valid_drop", 32'(spi_cmd_valid_o), 32'd0);
    check("clr_busy", 32'(busy_o), 32'd0);
    do_fwd(fwd_word(), 0, 1'b0);
    do_rpt(16'd4);
    clr_i = 1'b1;
    @(negedge clk_i);
    clr_i = 1'b0;
    m_rpt_pend = 1'b0;
    do_fwd(fwd_word(), 1, 1'b0);

    // Asynchronous reset in WAIT_CNT and in a stalled FWD.
    send({4'h5, 20'h0, 8'd5});
    @(negedge clk_i);
    pulse_reset("rst_wait");
    do_fwd(fwd_word(), 0, 1'b0);
    do_rpt(16'd2);
    send(fwd_word());
    @(negedge clk_i);
    pulse_reset("rst_fwd");
    do_fwd(fwd_word(), 0, 1'b0);

    // Random command stream.
    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 8);
      case (kind)
        0, 1, 2: do_fwd(fwd_word(), $urandom_range(0, 2), 1'b1);
        3: do_rpt(16'($urandom_range(0, 4)));
        4: do_wait(8'($urandom_range(0, 6)));
        5: do_wait_idle();
        6: do_eot(1'($urandom_range(0, 1)), $urandom_range(0, 3));
        7: do_setup(($urandom_range(0, 1) != 0) ? 4'hD : 4'hE);
        default: do_fwd(fwd_word(), 0, 1'b0);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
